// File: rtl/edc_write_through_cache_pkg.sv
// Shared widths, miss-FSM states and SEC-DED helpers for the
// write-through data cache.
package edc_write_through_cache_pkg;

    localparam int DATA_W    = 32;
    localparam int PAR_W     = 7;
    localparam int MEM_AW    = 13;
    localparam int IDX_W     = 9;
    localparam int TAG_W     = MEM_AW - IDX_W;
    localparam int LINES     = 1 << IDX_W;
    localparam int MEM_WORDS = 1 << MEM_AW;
    localparam int CW_LEN    = 38;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FILL
    } state_e;

    // Data bit j sits at the j-th non-power-of-two Hamming position.
    function automatic logic [PAR_W-1:0] secded_encode(
        input logic [DATA_W-1:0] data
    );
        logic [PAR_W-1:0] chk;
        int j;
        chk = '0;
        j = 0;
        for (int p = 1; p <= CW_LEN; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int k = 0; k < 6; k++) begin
                    if (p[k]) chk[k] = chk[k] ^ data[j];
                end
                j++;
            end
        end
        chk[6] = ^{data, chk[5:0]};
        return chk;
    endfunction

    // Returns {overall parity error, 6-bit syndrome}.
    function automatic logic [PAR_W-1:0] secded_syndrome(
        input logic [DATA_W-1:0] data,
        input logic [PAR_W-1:0]  chk
    );
        logic [PAR_W-1:0] calc;
        calc = secded_encode(data);
        return {^{data, chk}, calc[5:0] ^ chk[5:0]};
    endfunction

    function automatic logic [DATA_W-1:0] secded_correct(
        input logic [DATA_W-1:0] data,
        input logic [5:0]        syn
    );
        logic [DATA_W-1:0] fixed;
        int j;
        fixed = data;
        j = 0;
        for (int p = 1; p <= CW_LEN; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (syn == p[5:0]) fixed[j] = ~fixed[j];
                j++;
            end
        end
        return fixed;
    endfunction

endpackage

// File: rtl/edc_write_through_cache_encoder.sv
// Combinational SEC-DED store encoder: data passes through,
// check bits are generated alongside.
module edc_store_encoder
    import edc_write_through_cache_pkg::*;
(
    input  logic [DATA_W-1:0] data_PC,
    output logic [DATA_W-1:0] data_Cache,
    output logic [PAR_W-1:0]  parity_Cache
);

    assign data_Cache   = data_PC;
    assign parity_Cache = secded_encode(data_PC);

endmodule

// File: rtl/edc_write_through_cache.sv
// Direct-mapped write-through cache with SEC-DED protected lines,
// a user port into the backing RAM and error-injection hooks.
module edc_write_through_cache
    import edc_write_through_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_read_en,
    input  logic              CPU_write_en,
    input  logic [31:0]       CPU_addr,
    input  logic [DATA_W-1:0] CPU_write_din,
    input  logic [PAR_W-1:0]  parity_bits,
    output logic [DATA_W-1:0] CPU_read_dout,
    output logic              isCacheStall,
    input  logic              mem_b_we,
    input  logic [MEM_AW-1:0] mem_b_addr,
    input  logic [DATA_W-1:0] mem_b_din,
    output logic [DATA_W-1:0] mem_b_dout,
    input  logic              error_dwe,
    input  logic              error_pwe,
    input  logic [DATA_W-1:0] error_din,
    input  logic [PAR_W-1:0]  error_pin,
    input  logic [IDX_W-1:0]  error_addr
);

    state_e state_q, state_d;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [PAR_W-1:0]  chk_q  [LINES];

    logic [DATA_W-1:0] ram_q [MEM_WORDS];
    logic [DATA_W-1:0] ra_q;
    logic [DATA_W-1:0] mb_dout_q;

    logic [MEM_AW-1:0] waddr;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  mb_idx;
    logic [TAG_W-1:0]  mb_tag;
    logic [DATA_W-1:0] line_data;
    logic [PAR_W-1:0]  line_chk;
    logic [PAR_W-1:0]  synd;
    logic              perr;
    logic              dbl;
    logic              hit;
    logic              rd_miss;
    logic              mb_inval;
    logic              stall_c;
    logic              cpu_we;
    logic              fill_we;
    logic              line_we;
    logic [DATA_W-1:0] fill_data;
    logic [PAR_W-1:0]  fill_chk;
    logic [DATA_W-1:0] line_wdata;
    logic [PAR_W-1:0]  line_wchk;
    logic              unused_addr_bits;

    assign waddr  = CPU_addr[14:2];
    assign idx    = CPU_addr[10:2];
    assign tag    = CPU_addr[14:11];
    assign mb_idx = mem_b_addr[IDX_W-1:0];
    assign mb_tag = mem_b_addr[MEM_AW-1:IDX_W];

    assign unused_addr_bits = ^{CPU_addr[31:15], CPU_addr[1:0]};

    assign line_data = data_q[idx];
    assign line_chk  = chk_q[idx];
    assign synd      = secded_syndrome(line_data, line_chk);
    assign perr      = synd[6];
    // Nonzero syndrome with good overall parity is uncorrectable.
    assign dbl       = (synd[5:0] != '0) && !perr;
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_miss   = CPU_read_en && !CPU_write_en && (!hit || dbl);

    assign CPU_read_dout = perr ? secded_correct(line_data, synd[5:0])
                                : line_data;

    edc_store_encoder u_fill_enc (
        .data_PC      (ra_q),
        .data_Cache   (fill_data),
        .parity_Cache (fill_chk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rd_miss) state_d = S_FETCH;
            S_FETCH: state_d = S_FILL;
            S_FILL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        cpu_we  = 1'b0;
        fill_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stall_c = rd_miss;
                cpu_we  = CPU_write_en;
            end
            S_FETCH: stall_c = 1'b1;
            S_FILL: begin
                stall_c = 1'b1;
                fill_we = 1'b1;
            end
            default: stall_c = 1'b0;
        endcase
    end

    assign isCacheStall = stall_c & rst;

    assign line_we    = cpu_we | fill_we;
    assign line_wdata = fill_we ? fill_data : CPU_write_din;
    assign line_wchk  = fill_we ? fill_chk  : parity_bits;

    assign mb_inval = mem_b_we && valid_q[mb_idx]
                   && (tag_q[mb_idx] == mb_tag);

    always_comb begin
        valid_d = valid_q;
        if (mb_inval) valid_d[mb_idx] = 1'b0;
        if (line_we)  valid_d[idx]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Injection first so that a same-line fill or store overrides it.
    always_ff @(posedge clk) begin
        if (error_dwe) data_q[error_addr] <= error_din;
        if (error_pwe) chk_q[error_addr]  <= error_pin;
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
            chk_q[idx]  <= line_wchk;
        end
    end

    // CPU write is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH) ra_q <= ram_q[waddr];
        mb_dout_q <= ram_q[mem_b_addr];
        if (mem_b_we) ram_q[mem_b_addr] <= mem_b_din;
        if (cpu_we)   ram_q[waddr]      <= CPU_write_din;
    end

    assign mem_b_dout = mb_dout_q;

endmodule

// File: tb/tb_edc_write_through_cache.sv
// Directed bench for the SEC-DED write-through cache.
module tb_edc_write_through_cache;
    import edc_write_through_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        CPU_read_en;
    logic        CPU_write_en;
    logic [31:0] CPU_addr;
    logic [31:0] CPU_write_din;
    logic [6:0]  parity_bits;
    logic [31:0] CPU_read_dout;
    logic        isCacheStall;
    logic        mem_b_we;
    logic [12:0] mem_b_addr;
    logic [31:0] mem_b_din;
    logic [31:0] mem_b_dout;
    logic        error_dwe;
    logic        error_pwe;
    logic [31:0] error_din;
    logic [6:0]  error_pin;
    logic [8:0]  error_addr;

    logic [31:0] enc_in;
    logic [31:0] enc_data;
    logic [6:0]  enc_par;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edc_write_through_cache dut (
        .clk           (clk),
        .rst           (rst),
        .CPU_read_en   (CPU_read_en),
        .CPU_write_en  (CPU_write_en),
        .CPU_addr      (CPU_addr),
        .CPU_write_din (CPU_write_din),
        .parity_bits   (parity_bits),
        .CPU_read_dout (CPU_read_dout),
        .isCacheStall  (isCacheStall),
        .mem_b_we      (mem_b_we),
        .mem_b_addr    (mem_b_addr),
        .mem_b_din     (mem_b_din),
        .mem_b_dout    (mem_b_dout),
        .error_dwe     (error_dwe),
        .error_pwe     (error_pwe),
        .error_din     (error_din),
        .error_pin     (error_pin),
        .error_addr    (error_addr)
    );

    edc_store_encoder u_enc (
        .data_PC      (enc_in),
        .data_Cache   (enc_data),
        .parity_Cache (enc_par)
    );

    assign CPU_write_din = enc_data;
    assign parity_bits   = enc_par;

    task automatic cpu_read(input logic [31:0] a, output int st,
                            output logic [31:0] d);
        @(negedge clk);
        CPU_addr    = a;
        CPU_read_en = 1'b1;
        st = 0;
        #1;
        while (isCacheStall === 1'b1 && st < 20) begin
            st++;
            @(negedge clk);
            #1;
        end
        d = CPU_read_dout;
        CPU_read_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] v,
                             output logic st);
        @(negedge clk);
        CPU_addr     = a;
        enc_in       = v;
        CPU_write_en = 1'b1;
        #1;
        st = isCacheStall;
        @(negedge clk);
        CPU_write_en = 1'b0;
    endtask

    task automatic user_write(input logic [12:0] a, input logic [31:0] v);
        @(negedge clk);
        mem_b_we   = 1'b1;
        mem_b_addr = a;
        mem_b_din  = v;
        @(negedge clk);
        mem_b_we   = 1'b0;
    endtask

    task automatic inject(input logic dwe, input logic pwe,
                          input logic [8:0] a, input logic [31:0] dv,
                          input logic [6:0] pv);
        @(negedge clk);
        error_dwe  = dwe;
        error_pwe  = pwe;
        error_addr = a;
        error_din  = dv;
        error_pin  = pv;
        @(negedge clk);
        error_dwe  = 1'b0;
        error_pwe  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        CPU_read_en = 1'b1;
        CPU_write_en = 1'b0;
        CPU_addr = 32'h40;
        mem_b_we = 1'b0;
        mem_b_addr = '0;
        mem_b_din = '0;
        error_dwe = 1'b0;
        error_pwe = 1'b0;
        error_din = '0;
        error_pin = '0;
        error_addr = '0;
        enc_in = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (isCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", isCacheStall);
        end
        CPU_read_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (isCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: got %b want 0", isCacheStall);
        end
    endtask

    task automatic test_encoder();
        logic [6:0] ref_chk;
        enc_in = 32'h0;
        #1;
        checks++;
        if (enc_par !== 7'h00) begin
            errors++;
            $display("FAIL enc_zero: got %h want 00", enc_par);
        end
        enc_in = 32'h1;
        #1;
        checks++;
        if (enc_par !== 7'h43) begin
            errors++;
            $display("FAIL enc_one: got %h want 43", enc_par);
        end
        enc_in = 32'hFFFF_FFFF;
        #1;
        ref_chk = secded_encode(32'hFFFF_FFFF);
        checks++;
        if (enc_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL enc_pass: got %h want ffffffff", enc_data);
        end
        checks++;
        if (enc_par !== 7'h18 || enc_par !== ref_chk) begin
            errors++;
            $display("FAIL enc_ones: got %h want 18 (fn %h)",
                     enc_par, ref_chk);
        end
    endtask

    task automatic test_cold_read();
        int st;
        logic [31:0] d;
        user_write(13'h10, 32'hDEAD_BEEF);
        cpu_read(32'h40, st, d);
        checks++;
        if (st != 3) begin
            errors++;
            $display("FAIL cold_stall: got %0d want 3", st);
        end
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cold_data: got %h want deadbeef", d);
        end
        cpu_read(32'h40, st, d);
        checks++;
        if (st != 0 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reread: got %0d/%h want 0/deadbeef", st, d);
        end
    endtask

    task automatic test_store_load();
        int st;
        logic ws;
        logic [31:0] d;
        cpu_write(32'h80, 32'h1234_5678, ws);
        checks++;
        if (ws !== 1'b0) begin
            errors++;
            $display("FAIL store_stall: got %b want 0", ws);
        end
        cpu_read(32'h80, st, d);
        checks++;
        if (st != 0 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_hit: got %0d/%h want 0/12345678", st, d);
        end
        @(negedge clk);
        mem_b_addr = 13'h20;
        @(negedge clk);
        #1;
        checks++;
        if (mem_b_dout !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mem_b_rd: got %h want 12345678", mem_b_dout);
        end
        mem_b_addr = 13'h10;
        @(negedge clk);
        #1;
        checks++;
        if (mem_b_dout !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mem_b_rd2: got %h want deadbeef", mem_b_dout);
        end
    endtask

    task automatic test_edc();
        int st;
        logic ws;
        logic [31:0] d;
        logic [6:0] good;
        good = secded_encode(32'h1234_5678);
        inject(1'b0, 1'b1, 9'h20, 32'h0, good ^ 7'h04);
        cpu_read(32'h80, st, d);
        checks++;
        if (st != 0 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL chk_err: got %0d/%h want 0/12345678", st, d);
        end
        cpu_write(32'h80, 32'h1234_5678, ws);
        inject(1'b1, 1'b0, 9'h20, 32'h1234_5679, 7'h0);
        cpu_read(32'h80, st, d);
        checks++;
        if (st != 0 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_err: got %0d/%h want 0/12345678", st, d);
        end
        inject(1'b1, 1'b0, 9'h20, 32'h1234_567B, 7'h0);
        cpu_read(32'h80, st, d);
        checks++;
        if (st != 3 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL double_err: got %0d/%h want 3/12345678", st, d);
        end
        cpu_read(32'h80, st, d);
        checks++;
        if (st != 0 || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL refetched: got %0d/%h want 0/12345678", st, d);
        end
    endtask

    task automatic test_conflict();
        int st;
        logic [31:0] d;
        user_write(13'h810, 32'hCAFE_F00D);
        cpu_read(32'h40, st, d);
        checks++;
        if (st != 0 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL conf_a: got %0d/%h want 0/deadbeef", st, d);
        end
        cpu_read(32'h2040, st, d);
        checks++;
        if (st != 3 || d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL conf_b: got %0d/%h want 3/cafef00d", st, d);
        end
        cpu_read(32'h2040, st, d);
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL conf_b_hit: got %0d want 0", st);
        end
        user_write(13'h810, 32'h0BAD_C0DE);
        cpu_read(32'h2040, st, d);
        checks++;
        if (st != 3 || d !== 32'h0BAD_C0DE) begin
            errors++;
            $display("FAIL coherence: got %0d/%h want 3/0badc0de", st, d);
        end
        cpu_read(32'h40, st, d);
        checks++;
        if (st != 3 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL conf_evict: got %0d/%h want 3/deadbeef", st, d);
        end
    endtask

    task automatic test_read_write();
        int st;
        logic [31:0] d;
        @(negedge clk);
        CPU_addr     = 32'h100;
        enc_in       = 32'h55AA_55AA;
        CPU_write_en = 1'b1;
        CPU_read_en  = 1'b1;
        #1;
        checks++;
        if (isCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL rw_stall: got %b want 0", isCacheStall);
        end
        @(negedge clk);
        CPU_write_en = 1'b0;
        CPU_read_en  = 1'b0;
        cpu_read(32'h100, st, d);
        checks++;
        if (st != 0 || d !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL rw_hit: got %0d/%h want 0/55aa55aa", st, d);
        end
    endtask

    task automatic test_reset_mid_miss();
        int st;
        logic [31:0] d;
        @(negedge clk);
        CPU_addr    = 32'h200;
        CPU_read_en = 1'b1;
        #1;
        checks++;
        if (isCacheStall !== 1'b1) begin
            errors++;
            $display("FAIL miss_start: got %b want 1", isCacheStall);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (isCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: got %b want 0", isCacheStall);
        end
        @(negedge clk);
        CPU_read_en = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (isCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got %b want 0", isCacheStall);
        end
        cpu_read(32'h100, st, d);
        checks++;
        if (st != 3 || d !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL post_rst: got %0d/%h want 3/55aa55aa", st, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_encoder();
        test_cold_read();
        test_store_load();
        test_edc();
        test_conflict();
        test_read_write();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/edc_write_through_cache.md
Name:
edc_write_through_cache

Overview:
- Data-memory block for the MEM stage. A direct-mapped, write-through, write-allocate cache of 512 one-word lines sits in front of an 8K-word backing RAM.
- Each cached word carries 7 SEC-DED check bits. These are produced on stores by a combinational encoder sub-block and checked on every read hit.
- A second, user port gives direct word access to the backing RAM.
- Error-injection ports corrupt cached data or check bits so the EDC path can be exercised.

Parameters:
- DATA_W, 32: data word width.
- PAR_W, 7: check-bit width (6 Hamming bits plus 1 overall parity bit).
- MEM_AW, 13: backing RAM word-address width.
- IDX_W, 9: cache index width (512 lines).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- CPU_read_en  in  1  load request.
- CPU_write_en  in  1  store request.
- CPU_addr  in  32  byte address. Word address = [14:2], index = [10:2], tag = [14:11]. Other bits are ignored.
- CPU_write_din  in  32  store data, after the encoder.
- parity_bits  in  7  check bits of CPU_write_din, from the encoder.
- CPU_read_dout  out  32  corrected load data (combinational).
- isCacheStall  out  1  pipeline hold.
- mem_b_we  in  1  user-port write enable.
- mem_b_addr  in  13  user-port word address.
- mem_b_din  in  32  user-port write data.
- mem_b_dout  out  32  user-port read data.
- error_dwe  in  1  overwrite cached data of line error_addr.
- error_pwe  in  1  overwrite check bits of line error_addr.
- error_din  in  32  injected data value.
- error_pin  in  7  injected check-bit value.
- error_addr  in  9  target line index.

Behaviour:
- Line contents: valid, tag[3:0], data[31:0], chk[6:0].
- Reset:
  - Clears all valid bits and puts the FSM in IDLE.
  - isCacheStall=0.
  - RAM and line data are not cleared.
- Encoding (encoder sub-block, combinational, also used internally on fills):
  - Data passes through unchanged.
  - Data bits d0..d31 occupy Hamming positions 1..38 that are not powers of two, in ascending order.
  - chk[k], k=0..5, is the XOR of the positions whose index has bit k set.
  - chk[6] is the XOR of all data bits and chk[5:0].
- Hit: valid and tag match.
- Read hit, syndrome check:
  - Syndrome 0 with overall parity OK: no error; dout = stored data.
  - Single-bit error: dout = corrected data. No stall, and the line is not rewritten.
  - Double error (nonzero syndrome with overall parity OK): treated as a miss and the line is refetched.
- Miss FSM, states IDLE, FETCH, FILL:
  - IDLE: read_en with a miss or double error raises isCacheStall combinationally and moves to FETCH, which issues the RAM read.
  - FETCH to FILL: FILL writes the line (valid=1, new tag, data, encoded chk) and returns to IDLE.
  - isCacheStall=1 in FETCH and FILL.
  - The next IDLE cycle is a hit: stall=0 and dout is valid.
  - A miss therefore costs 3 stall cycles. The CPU holds its inputs while isCacheStall=1.
- Write (IDLE only, no stall):
  - The RAM word is written.
  - The line is written with valid=1, tag, CPU_write_din and parity_bits.
  - If read_en and write_en are both high, the write is performed and the read is ignored (stall=0).
- User port:
  - Synchronous RAM, read-first, 1-cycle read latency.
  - A write to an address whose line currently holds that address clears that line's valid bit.
  - On a same-cycle same-address RAM write collision, the CPU write wins.
- Error injection:
  - error_dwe and error_pwe take effect at the clock edge and do not change valid, tag or the RAM.
  - A FILL to the same line in the same cycle overrides the injection.
- A reset assertion mid-miss aborts the fill and returns to IDLE with all lines invalid.

Decomposition:
- Shared package:
  - Width constants.
  - FSM state enum.
  - Functions secded_encode(data) returning chk, and secded_syndrome.
- Sub-module edc_store_encoder:
  - Ports data_PC (in 32), data_Cache (out 32) and parity_Cache (out 7).
  - Purely combinational; the parent instantiates it.

Test Plan:
- Encoder:
  - data_PC=0 -> parity 7'h00.
  - data_PC=1 -> parity 7'h43.
  - data_PC=32'hFFFFFFFF -> data_Cache equals the input and chk equals the package function.
- Cold read:
  - Preload RAM[0x10]=32'hDEADBEEF via the user port; read CPU_addr=0x40.
  - Required: stall high for exactly 3 cycles, then dout=DEADBEEF with stall low.
  - Re-read of 0x40: no stall.
- Store then load:
  - Write 32'h12345678 to 0x80 -> no stall.
  - Read 0x80 -> hit, dout=12345678.
  - mem_b_dout at address 0x20 = 12345678 one cycle after the address is applied.
- Single-bit error:
  - After the store above, inject error_dwe with error_addr=0x20 and error_din=32'h12345679.
  - Read 0x80 -> dout=12345678, no stall.
- Double-bit error:
  - Inject error_din=32'h1234567B.
  - Read 0x80 -> 3-cycle stall, refetch, dout=12345678.
- Conflict, coherence and reset:
  - Read 0x40, then 0x2040 (same index) -> second read misses.
  - User write to 0x810 -> next read of 0x2040 misses and returns the new value.
  - rst=0 mid-FETCH -> stall drops immediately and the next read misses.
